// File: rtl/branch_predictor.sv
// IF-stage branch predictor: 2-bit saturating BHT, direct-mapped BTB, and a 3-deep pipe that carries each prediction to EX/MEM.
// Optional BP_GSHARE_EN: XOR the BHT index with a non-speculative global history register.
module branch_predictor #(
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    input  logic            stall,
    input  logic            clear,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    output logic            prediction_checkout_ex_mem
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = XLEN - BTB_IDX_W - 2;

    typedef struct packed {
        logic                 pred;
        logic [BHT_IDX_W-1:0] bidx;
    } track_t;

    logic [1:0]           bht_q [BHT_N];
    logic [1:0]           bht_cnt_next;
    logic [BTB_N-1:0]     btb_valid_reg;
    logic [TAG_W-1:0]     btb_tag_reg [BTB_N];
    logic [XLEN-1:0]      btb_target_reg [BTB_N];
    track_t               ifid_reg, idex_reg, exmem_reg;

    logic [BHT_IDX_W-1:0] lookup_bidx;
    logic [BTB_IDX_W-1:0] lookup_tidx;
    logic [TAG_W-1:0]     lookup_tag;
    logic                 btb_hit;
    logic [BTB_IDX_W-1:0] upd_tidx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 unused_upd_pc_lsbs;

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

`ifdef BP_GSHARE_EN
    logic [BHT_IDX_W-1:0] ghr_reg;

    // History advances only on resolved branches, never on fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg <= '0;
        end else if (upd_valid) begin
            ghr_reg <= {ghr_reg[BHT_IDX_W-2:0], upd_taken};
        end
    end

    assign lookup_bidx = if_pc[BHT_IDX_W+1:2] ^ ghr_reg;
`else
    assign lookup_bidx = if_pc[BHT_IDX_W+1:2];
`endif

    assign lookup_tidx = if_pc[BTB_IDX_W+1:2];
    assign lookup_tag  = if_pc[XLEN-1:BTB_IDX_W+2];
    assign upd_tidx    = upd_pc[BTB_IDX_W+1:2];
    assign upd_tag     = upd_pc[XLEN-1:BTB_IDX_W+2];

    // Lookup reads the tables as they were before this cycle's update edge.
    assign btb_hit      = btb_valid_reg[lookup_tidx] && (btb_tag_reg[lookup_tidx] == lookup_tag);
    assign pred_taken   = bht_q[lookup_bidx][1] && btb_hit;
    assign pred_next_pc = pred_taken ? btb_target_reg[lookup_tidx] : if_pc + XLEN'(4);

    assign prediction_checkout_ex_mem = exmem_reg.pred;

    always_comb begin
        bht_cnt_next = bht_q[exmem_reg.bidx];
        if (upd_taken) begin
            if (bht_cnt_next != 2'b11) begin
                bht_cnt_next = bht_cnt_next + 2'b01;
            end
        end else if (bht_cnt_next != 2'b00) begin
            bht_cnt_next = bht_cnt_next - 2'b01;
        end
    end

    // Training uses the index carried down the pipe, so it matches what was looked up at fetch.
    for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
        logic [1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= 2'b01;
            end else if (upd_valid && (exmem_reg.bidx == BHT_IDX_W'(gi))) begin
                cnt_reg <= bht_cnt_next;
            end
        end

        assign bht_q[gi] = cnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_reg <= '0;
        end else if (upd_valid && upd_taken) begin
            btb_valid_reg[upd_tidx] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset: an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag_reg[upd_tidx]    <= upd_tag;
            btb_target_reg[upd_tidx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_reg  <= '0;
            idex_reg  <= '0;
            exmem_reg <= '0;
        end else if (clear) begin
            ifid_reg  <= '0;
            idex_reg  <= '0;
            exmem_reg <= '0;
        end else begin
            exmem_reg <= idex_reg;
            if (stall) begin
                idex_reg <= '0;
            end else begin
                idex_reg <= ifid_reg;
                ifid_reg <= '{pred: pred_taken, bidx: lookup_bidx};
            end
        end
    end

endmodule
